// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;
   typedef enum logic [2:0] {RST, REQ, WAIT, HOLD, REDIR, ERR} fetch_state_t;
   localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/fetch_timeout_ctr.sv
// Per-fetch watchdog: counts cycles while enabled, flags expiry on the TIMEOUT-th cycle.
module fetch_timeout_ctr #(
   parameter int TIMEOUT = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_reg;

   // TIMEOUT of zero disables expiry; the counter then just free-runs harmlessly
   assign expired = (TIMEOUT != 0) && enable && (cnt_reg == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_reg <= '0;
      else if (clear)
         cnt_reg <= '0;
      else if (enable && !expired)
         cnt_reg <= cnt_reg + CW'(1);
   end
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: single-outstanding imem handshake, decode hold buffer and redirect handling.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int ILEN    = 32,
   parameter int TIMEOUT = 256
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] pc_f,
   output logic [WIDTH-1:0] pc_next,
   output logic             stall_f,
   input  logic             hazard_stall,
   input  logic             redirect,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_gnt,
   input  logic             imem_rvalid,
   input  logic [ILEN-1:0]  imem_rdata,
   output logic             instr_valid,
   output logic [ILEN-1:0]  instr,
   output logic [WIDTH-1:0] instr_pc,
   output logic             fetch_err
);
   fetch_state_t     state_reg, state_next;
   logic [ILEN-1:0]  instr_reg;
   logic [WIDTH-1:0] instr_pc_reg;
   logic [WIDTH-1:0] tgt_reg;
   logic             discard_reg;
   logic             in_fetch;
   logic             expired;

   assign in_fetch = (state_reg == REQ) || (state_reg == WAIT);

   fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (!in_fetch),
      .enable  (in_fetch),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_reg <= RST;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         RST:   state_next = redirect ? REDIR : REQ;
         REQ: begin
            if (expired)
               state_next = ERR;
            else if (imem_gnt)
               state_next = WAIT;
         end
         WAIT: begin
            if (expired)
               state_next = ERR;
            else if (imem_rvalid)
               state_next = (discard_reg || redirect) ? REDIR : HOLD;
         end
         HOLD: begin
            if (redirect || !hazard_stall)
               state_next = REQ;
         end
         REDIR: state_next = REQ;
         ERR:   state_next = ERR;
         default: state_next = RST;
      endcase
   end

   always_comb begin
      imem_req  = (state_reg == REQ);
      imem_addr = pc_f;
      stall_f   = 1'b1;
      pc_next   = pc_f + WIDTH'(INSTR_BYTES);
      unique case (state_reg)
         RST: pc_next = '0;
         HOLD: begin
            if (redirect) begin
               stall_f = 1'b0;
               pc_next = redirect_pc;
            end else if (!hazard_stall) begin
               stall_f = 1'b0;
            end
         end
         // A redirect arriving while the pending one is applied supersedes it
         REDIR: begin
            stall_f = 1'b0;
            pc_next = redirect ? redirect_pc : tgt_reg;
         end
         default: ;
      endcase
   end

   assign instr_valid = (state_reg == HOLD);
   assign fetch_err   = (state_reg == ERR);
   assign instr       = instr_reg;
   assign instr_pc    = instr_pc_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_reg    <= '0;
         instr_pc_reg <= '0;
         tgt_reg      <= '0;
         discard_reg  <= 1'b0;
      end else begin
         if (state_reg == WAIT && state_next == HOLD) begin
            instr_reg    <= imem_rdata;
            instr_pc_reg <= pc_f;
         end
         if (redirect)
            tgt_reg <= redirect_pc;
         // An outstanding request must still complete; its response is marked stale
         if (in_fetch && redirect)
            discard_reg <= 1'b1;
         else if (state_reg == REDIR)
            discard_reg <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: memory responder, PC register and fetch-stream scoreboard.
module tb_fetch_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc_f, pc_next, redirect_pc, imem_addr, imem_rdata, instr, instr_pc;
   logic        stall_f, hazard_stall, redirect, imem_req, imem_gnt, imem_rvalid;
   logic        instr_valid, fetch_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fetch_ctrl #(.WIDTH(32), .ILEN(32), .TIMEOUT(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pc_f         (pc_f),
      .pc_next      (pc_next),
      .stall_f      (stall_f),
      .hazard_stall (hazard_stall),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_gnt     (imem_gnt),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .instr_valid  (instr_valid),
      .instr        (instr),
      .instr_pc     (instr_pc),
      .fetch_err    (fetch_err)
   );

   // PC register held in reset alongside the fetch block
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pc_f <= 32'h0;
      else if (!stall_f)
         pc_f <= pc_next;
   end

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   // Instruction memory: random grant delay, random response latency (>=1 after grant)
   int          gnt_dly_max = 0;
   int          lat_min     = 1;
   int          lat_max     = 1;
   bit          mem_on      = 1'b1;
   int          gnt_cd      = 0;
   bit          gnt_q       = 1'b0;
   bit          busy        = 1'b0;
   int          rsp_wait    = 0;
   logic [31:0] addr_q      = 32'h0;
   logic [31:0] rsp_addr    = 32'h0;

   initial begin
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      forever begin
         @(negedge clk);
         imem_rvalid = 1'b0;
         imem_gnt    = 1'b0;
         if (!rst_n) begin
            gnt_q  = 1'b0;
            busy   = 1'b0;
            gnt_cd = 0;
         end else begin
            if (gnt_q) begin
               busy     = 1'b1;
               rsp_addr = addr_q;
               rsp_wait = int'($urandom_range(lat_max, lat_min));
               gnt_q    = 1'b0;
            end
            if (busy) begin
               if (rsp_wait <= 1) begin
                  imem_rvalid = 1'b1;
                  imem_rdata  = memf(rsp_addr);
                  busy        = 1'b0;
               end else begin
                  rsp_wait--;
               end
            end
            if (imem_req && mem_on) begin
               if (gnt_cd == 0) begin
                  imem_gnt = 1'b1;
                  gnt_q    = 1'b1;
                  addr_q   = imem_addr;
                  gnt_cd   = int'($urandom_range(gnt_dly_max, 0));
               end else begin
                  gnt_cd--;
               end
            end
         end
      end
   end

   // Scoreboard: next delivered address is last consumed + 4, or the latest redirect target
   logic [31:0] exp_pc     = 32'h0;
   bit          prev_valid = 1'b0;
   int          consumed   = 0;
   int          stall0     = 0;
   int          deliveries = 0;

   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (!rst_n) begin
            exp_pc     = 32'h0;
            prev_valid = 1'b0;
         end else begin
            if (instr_valid && !prev_valid) begin
               deliveries++;
               chk("deliver_pc", instr_pc, exp_pc);
               chk("deliver_data", instr, memf(exp_pc));
               chk("pc_f_at_hold", pc_f, instr_pc);
               $display("deliver pc=%08h instr=%08h", instr_pc, instr);
            end
            if (instr_valid && !redirect)
               chkb("hold_stall", stall_f, hazard_stall);
            if (!stall_f)
               stall0++;
            if (redirect)
               exp_pc = redirect_pc;
            else if (instr_valid && !hazard_stall) begin
               exp_pc = exp_pc + 32'd4;
               consumed++;
            end
            prev_valid = instr_valid;
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_deliver(input logic [31:0] pc, input string tag, output int n);
      n = 0;
      while (!(instr_valid && instr_pc == pc) && n < 40) begin
         step();
         n++;
      end
      chkb(tag, instr_valid && (instr_pc == pc), 1'b1);
   endtask

   task automatic pulse_redirect(input logic [31:0] tgt);
      redirect    = 1'b1;
      redirect_pc = tgt;
      step();
      redirect    = 1'b0;
   endtask

   initial begin
      int n;
      int reqs;
      rst_n        = 1'b0;
      hazard_stall = 1'b0;
      redirect     = 1'b0;
      redirect_pc  = 32'h0;
      repeat (2) step();

      chkb("rst_req", imem_req, 1'b0);
      chkb("rst_stall", stall_f, 1'b1);
      chk ("rst_pc_next", pc_next, 32'h0);
      chkb("rst_valid", instr_valid, 1'b0);
      chk ("rst_instr", instr, 32'h0);
      chk ("rst_instr_pc", instr_pc, 32'h0);
      chkb("rst_err", fetch_err, 1'b0);

      // Zero-wait memory: back-to-back fetches every gnt+rvalid+2 cycles
      rst_n = 1'b1;
      wait_deliver(32'h0, "zw_first", n);
      step();
      wait_deliver(32'h8, "zw_pc8", n);
      chk("zw_two_instr_cycles", 32'(n + 1), 32'd6);
      chk("zw_stall_once", 32'(stall0), 32'(consumed));

      // Decode back-pressure for 5 cycles while holding 0x8
      hazard_stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chkb("hz_stall", stall_f, 1'b1);
         chk ("hz_pc_f", pc_f, 32'h8);
         chk ("hz_instr_pc", instr_pc, 32'h8);
         chk ("hz_instr", instr, memf(32'h8));
         step();
      end
      hazard_stall = 1'b0;
      #1;
      chkb("hz_release_stall", stall_f, 1'b0);
      chk ("hz_release_pc_next", pc_next, 32'hC);
      step();
      chk("hz_pc_f_next", pc_f, 32'hC);

      // Redirect while waiting on the response for 0x10
      lat_min = 3;
      lat_max = 3;
      n = 0;
      while (!(busy && rsp_addr == 32'h10) && n < 40) begin
         step();
         n++;
      end
      chkb("rd_wait_0x10", busy && (rsp_addr == 32'h10), 1'b1);
      pulse_redirect(32'h100);
      wait_deliver(32'h100, "rd_target", n);

      // Two redirects against one outstanding fetch; the newer wins
      n = 0;
      while (!imem_req && n < 40) begin
         step();
         n++;
      end
      chkb("rd2_req_seen", imem_req, 1'b1);
      pulse_redirect(32'h200);
      pulse_redirect(32'h300);
      wait_deliver(32'h300, "rd2_target", n);

      // Redirect in HOLD beats hazard_stall
      hazard_stall = 1'b1;
      pulse_redirect(32'h40);
      chkb("rdh_valid_drop", instr_valid, 1'b0);
      chk ("rdh_pc_f", pc_f, 32'h40);
      hazard_stall = 1'b0;

      // Random traffic, back-pressure and redirects (some near the top of the address space)
      gnt_dly_max = 2;
      lat_min     = 1;
      lat_max     = 3;
      n           = deliveries;
      for (int i = 0; i < 500; i++) begin
         hazard_stall = ($urandom_range(3, 0) == 0);
         redirect     = ($urandom_range(19, 0) == 0);
         redirect_pc  = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(255, 0)) << 2);
         step();
      end
      redirect     = 1'b0;
      hazard_stall = 1'b0;
      chkb("rand_progress", (deliveries - n) > 20, 1'b1);

      // Timeout: grant never arrives
      rst_n  = 1'b0;
      mem_on = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      reqs  = 0;
      n     = 0;
      while (!fetch_err && n < 20) begin
         step();
         n++;
         if (imem_req)
            reqs++;
      end
      chkb("to_err_set", fetch_err, 1'b1);
      chk ("to_req_cycles", 32'(reqs), 32'd8);
      mem_on = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chkb("to_err_sticky", fetch_err, 1'b1);
         chkb("to_no_req", imem_req, 1'b0);
         chkb("to_stall", stall_f, 1'b1);
         chkb("to_no_valid", instr_valid, 1'b0);
      end
      rst_n = 1'b0;
      #1;
      chkb("to_rst_clears", fetch_err, 1'b0);
      chkb("to_rst_req", imem_req, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
